// File: rtl/mod_ex_multicycle_seq.sv
// Execute-stage sequencer for multi-cycle ops: signed IMUL (shift-add)
// and SHL/SHR (one bit per cycle), with valid/ready on both sides.
module mod_ex_multicycle_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_opcode,
  input  logic [3:0]      in_regbyte,
  input  logic [3:0]      in_rmbyte,
  input  logic            in_shdir,
  input  logic [0:XLEN-1] in_opa,
  input  logic [0:XLEN-1] in_opb,
  input  logic [0:XLEN-1] in_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:XLEN-1] out_result,
  output logic [0:XLEN-1] out_ext_result,
  output logic [3:0]      out_rmbyte,
  output logic [3:0]      out_regbyte,
  output logic [7:0]      out_opcode,
  output logic            out_zf,
  output logic            out_cf,
  output logic            busy
);

  localparam int LW = $clog2(XLEN);
  localparam int CW = (CNT_W > LW) ? CNT_W : LW;

  typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic              sign;
  logic [XLEN-1:0]   sh;
  logic              shdir;
  logic [7:0]        op_q;
  logic [3:0]        reg_q;
  logic [3:0]        rm_q;

  logic [XLEN-1:0]   opa_d;
  logic [XLEN-1:0]   opb_d;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [CNT_W-1:0]  n;
  logic              is_mul;
  logic              is_sh;
  logic [2*XLEN-1:0] acc_add;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sh_nxt;
  logic              sh_out;
  logic              fin;
  logic [XLEN-1:0]   fin_res;
  logic [XLEN-1:0]   fin_ext;
  logic              fin_cf;
  logic              unused_imm;

  // Numeric value is position-preserving; internal math uses [N-1:0].
  assign opa_d      = in_opa;
  assign opb_d      = in_opb;
  assign n          = in_imm[XLEN-CNT_W:XLEN-1];
  assign unused_imm = ^in_imm[0:XLEN-CNT_W-1];
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    is_mul  = (in_opcode == 8'd247);
    is_sh   = (in_opcode == 8'd193) ||
              (in_opcode == 8'd209) ||
              (in_opcode == 8'd211);
    abs_a   = opa_d[XLEN-1] ? -opa_d : opa_d;
    abs_b   = opb_d[XLEN-1] ? -opb_d : opb_d;
    acc_add = acc + (mplier[0] ? mcand : '0);
    prod    = sign ? -acc_add : acc_add;
    sh_nxt  = shdir ? (sh << 1) : (sh >> 1);
    sh_out  = shdir ? sh[XLEN-1] : sh[0];
  end

  // Result of the edge that enters DONE, whichever path gets there.
  always_comb begin
    fin     = 1'b0;
    fin_res = '0;
    fin_ext = '0;
    fin_cf  = 1'b0;
    unique case (state)
      IDLE: begin
        fin     = in_valid && !(is_mul || (is_sh && n != '0));
        fin_res = opa_d;
      end
      MUL: begin
        fin     = (cnt == CW'(XLEN-1));
        fin_res = prod[XLEN-1:0];
        fin_ext = prod[2*XLEN-1:XLEN];
        fin_cf  = (fin_ext != {XLEN{fin_res[XLEN-1]}});
      end
      SHIFT: begin
        fin     = (cnt == CW'(1));
        fin_res = sh_nxt;
        fin_cf  = sh_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      sign           <= 1'b0;
      sh             <= '0;
      shdir          <= 1'b0;
      op_q           <= '0;
      reg_q          <= '0;
      rm_q           <= '0;
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_ext_result <= '0;
      out_rmbyte     <= '0;
      out_regbyte    <= '0;
      out_opcode     <= '0;
      out_zf         <= 1'b0;
      out_cf         <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fin) begin
        state          <= DONE;
        out_valid      <= 1'b1;
        out_result     <= fin_res;
        out_ext_result <= fin_ext;
        out_cf         <= fin_cf;
        out_zf         <= (fin_res == '0);
        out_opcode     <= (state == IDLE) ? in_opcode : op_q;
        out_regbyte    <= (state == IDLE) ? in_regbyte : reg_q;
        out_rmbyte     <= (state == IDLE) ? in_rmbyte : rm_q;
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= in_opcode;
            reg_q <= in_regbyte;
            rm_q  <= in_rmbyte;
            if (is_mul) begin
              acc    <= '0;
              mcand  <= {{XLEN{1'b0}}, abs_a};
              mplier <= abs_b;
              sign   <= opa_d[XLEN-1] ^ opb_d[XLEN-1];
              cnt    <= '0;
              state  <= MUL;
            end else if (is_sh && n != '0) begin
              sh    <= opa_d;
              shdir <= in_shdir;
              cnt   <= CW'(n);
              state <= SHIFT;
            end
          end
        end
        MUL: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        SHIFT: begin
          sh  <= sh_nxt;
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_ex_multicycle_seq.md
Name: mod_ex_multicycle_seq

Overview:
Sequencer for the execute stage's multi-cycle operations: signed IMUL (RDX:RAX = RAX * r64) and the SHL/SHR group.
- Accepts one op from the MEM/EX latch with a valid/ready handshake and stalls upstream while busy.
- Computes iteratively: one multiply step or one shift per cycle.
- Holds the result and flags until writeback accepts them.
- Replaces the combinational 128-bit multiply and the unbounded shift loops in the execute datapath.

Parameters:
- XLEN, 64, operand width in bits; LSB is bit XLEN-1 (big-endian [0:XLEN-1] indexing, as in the pipeline registers).
- CNT_W, 6, shift-count width; the count is taken modulo 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- in_valid  in  1  MEM/EX presents an op.
- in_ready  out  1  block can accept; equals (state==IDLE).
- in_opcode  in  8  primary opcode: 247 = IMUL; 193/209/211 = shift; anything else = bypass.
- in_regbyte  in  4  ModRM reg field, forwarded to writeback with the result.
- in_rmbyte  in  4  destination register index.
- in_shdir  in  1  shifts only: 1 = left, 0 = right (logical).
- in_opa  in  XLEN  RAX for IMUL; shift source for shifts.
- in_opb  in  XLEN  multiplier register value for IMUL.
- in_imm  in  XLEN  shift count; bits [XLEN-CNT_W:XLEN-1] are used.
- flush  in  1  synchronous abort of any in-flight or held op.
- out_valid  out  1  result valid for writeback.
- out_ready  in  1  writeback accepts the result.
- out_result  out  XLEN  low half (RAX) or shift result.
- out_ext_result  out  XLEN  high half (RDX) for IMUL; 0 otherwise.
- out_rmbyte  out  4  registered copy of in_rmbyte.
- out_regbyte  out  4  registered copy of in_regbyte.
- out_opcode  out  8  registered copy of in_opcode.
- out_zf  out  1  1 when out_result == 0.
- out_cf  out  1  carry, defined per op below.
- busy  out  1  state != IDLE; used as the stall request to fetch/decode.

Behaviour:
- **Reset** (async, any state): state = IDLE, iteration counter = 0. All outputs are 0 except in_ready = 1.
- **States:** IDLE, MUL, SHIFT, DONE.
- **Accept:** when in_valid && in_ready && !flush at a rising edge, latch opcode, regbyte, rmbyte, shdir, operands and count.
- **IMUL:**
  - On accept: compute |opa| and |opb| (unsigned, so 0x8000_0000_0000_0000 stays as is); save sign = opa[0] ^ opb[0]; clear the 128-bit accumulator; go to MUL.
  - In MUL, each cycle: add the multiplicand when the current multiplier LSB is 1; shift the accumulator right by 1 (or the multiplicand left); counter++.
  - After exactly 64 MUL cycles, negate the 128-bit product if sign = 1, then go to DONE.
  - out_valid rises on the 65th rising edge after the accept edge.
  - out_cf = 1 when out_ext_result is not the sign-extension of out_result[0].
- **Shift:**
  - n = count mod 64. If n == 0: go straight to DONE (out_valid one edge after accept), result = opa, cf = 0.
  - Otherwise: SHIFT for n cycles, one bit per cycle, then DONE. out_valid rises n+1 edges after accept.
  - out_cf = last bit shifted out: bit 0 for left shifts, bit XLEN-1 for right shifts.
  - out_ext_result = 0.
- **Bypass** (other opcodes): go directly to DONE with result = opa, ext = 0, cf = 0.
- **out_zf:** evaluated on the final out_result for every op.
- **DONE:**
  - out_valid = 1; all outputs stay stable while out_ready = 0.
  - out_valid && out_ready → IDLE. out_valid falls at the next edge and in_ready rises; no same-cycle re-accept.
- **flush:**
  - In any state, next edge → IDLE and out_valid = 0; the in-flight result is discarded.
  - flush has priority over out_ready and over in_valid in the same cycle.
- **Reset mid-op:** immediate IDLE. No partial result is ever presented.
- **Registered outputs:** out_result, out_ext_result and the flags are registers, loaded only on the entry edge to DONE. They hold their values in IDLE until the next DONE entry.
- **Single outstanding op:** at most one op in flight. in_valid is ignored while in_ready = 0, and the upstream latch must hold its op.

Test Plan:
1. IMUL opa = 3, opb = 0xFFFF_FFFF_FFFF_FFFB (-5) → out_result = 0xFFFF_FFFF_FFFF_FFF1, ext = 0xFFFF_FFFF_FFFF_FFFF, cf = 0, zf = 0; out_valid exactly 65 edges after accept; busy high throughout.
2. IMUL opa = 0x8000_0000_0000_0000, opb = 2 → result = 0, ext = 0xFFFF_FFFF_FFFF_FFFF, cf = 1, zf = 1.
3. Shift left, opa = 1, imm = 4 → result = 0x10, cf = 0, valid after 5 edges. Shift right, opa = 0x3, imm = 1 → result = 1, cf = 1. imm = 64 → treated as 0: result = opa, valid after 1 edge.
4. Backpressure: hold out_ready = 0 for 10 cycles in DONE → outputs stable, in_ready = 0, a new in_valid is ignored. out_ready = 1 → IDLE next edge, then the next op is accepted.
5. flush asserted at MUL iteration 20 → IDLE next edge, out_valid never rises. flush together with in_valid in IDLE → nothing is accepted.
6. reset pulsed asynchronously mid-SHIFT (between edges) → outputs clear immediately, in_ready = 1; the next IMUL 7*6 gives result 42, ext 0.
